// File: rtl/seq_alu_if.sv
// seq_alu_if -- operation/result bundle for seq_alu.
//   master : drives in_valid, SrcA, SrcB, ALUControl, out_ready
//            observes in_ready, out_valid, ALUResult, Zero, Illegal
//   slave  : the ALU side (opposite directions)
// WIDTH must match the WIDTH of the seq_alu instance it connects to.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [3:0]       ALUControl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;
   logic             Illegal;

   modport master (
      output in_valid, SrcA, SrcB, ALUControl, out_ready,
      input  in_ready, out_valid, ALUResult, Zero, Illegal
   );

   modport slave (
      input  in_valid, SrcA, SrcB, ALUControl, out_ready,
      output in_ready, out_valid, ALUResult, Zero, Illegal
   );
endinterface

// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU with valid/ready handshakes.
// Single-cycle ops (add/sub/logic/compare/shift and the two unassigned
// opcodes) go IDLE -> DONE. MUL/MULHU (shift-add) and DIVU/REMU
// (restoring division) take one bit per cycle: IDLE -> BUSY (WIDTH cycles)
// -> DONE. The result is held in DONE until out_ready.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : seq_alu_if.slave (operands/opcode in, result/flags out)
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       reset_n,
   seq_alu_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] BUSY = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SRL   = 4'b0110;
   localparam logic [3:0] OP_SLL   = 4'b0111;
   localparam logic [3:0] OP_SRA   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;

   logic [1:0]       state;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   // Iterative datapath. For multiply: hi = partial product high half,
   // lo = multiplier shifting out / product low half, opnd = multiplicand.
   // For divide: hi = partial remainder, lo = dividend shifting out /
   // quotient shifting in, opnd = divisor.
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] opnd;
   logic [CNT_W-1:0] cnt;
   logic             op_div;   // 1: DIVU/REMU, 0: MUL/MULHU
   logic             op_hi;    // 1: result from hi (MULHU/REMU)

   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_next;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   tmp;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] fin;

   logic [WIDTH-1:0] quick_res;
   logic             quick_ill;
   logic             is_multi;
   logic [SHW-1:0]   shamt;

   assign bus.in_ready  = (state == IDLE) && reset_n;
   assign bus.out_valid = (state == DONE);
   assign bus.ALUResult = result;
   assign bus.Zero      = zero;
   assign bus.Illegal   = illegal;

   // Single-cycle result, computed straight from the operands at accept.
   always_comb begin
      quick_res = '0;
      quick_ill = 1'b0;
      is_multi  = 1'b0;
      shamt     = bus.SrcB[SHW-1:0];
      case (bus.ALUControl)
         OP_ADD:   quick_res = bus.SrcA + bus.SrcB;
         OP_SUB:   quick_res = bus.SrcA - bus.SrcB;
         OP_AND:   quick_res = bus.SrcA & bus.SrcB;
         OP_OR:    quick_res = bus.SrcA | bus.SrcB;
         OP_XOR:   quick_res = bus.SrcA ^ bus.SrcB;
         OP_SLT:   quick_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
         OP_SRL:   quick_res = bus.SrcA >> shamt;
         OP_SLL:   quick_res = bus.SrcA << shamt;
         OP_SRA:   quick_res = WIDTH'($signed(bus.SrcA) >>> shamt);
         OP_SLTU:  quick_res = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
         OP_MUL,
         OP_MULHU,
         OP_DIVU,
         OP_REMU:  is_multi  = 1'b1;
         default:  quick_ill = 1'b1;
      endcase
   end

   // One iteration of shift-add multiply or restoring division.
   always_comb begin
      hi_next = hi;
      lo_next = lo;
      sum     = '0;
      tmp     = '0;
      diff    = '0;
      if (!op_div) begin
         sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
         hi_next = sum[WIDTH:1];
         lo_next = {sum[0], lo[WIDTH-1:1]};
      end else begin
         // Remainder stays below the divisor, so bit WIDTH of the
         // difference is a clean borrow flag. A zero divisor never
         // borrows: quotient becomes all ones and the remainder
         // collects the dividend unchanged.
         tmp  = {hi, lo[WIDTH-1]};
         diff = tmp - {1'b0, opnd};
         if (!diff[WIDTH]) begin
            hi_next = diff[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_next = tmp[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
         end
      end
      fin = op_hi ? hi_next : lo_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         result  <= '0;
         zero    <= 1'b1;
         illegal <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         opnd    <= '0;
         cnt     <= '0;
         op_div  <= 1'b0;
         op_hi   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (is_multi) begin
                     state  <= BUSY;
                     cnt    <= CNT_W'(WIDTH - 1);
                     hi     <= '0;
                     op_div <= bus.ALUControl[2];
                     op_hi  <= bus.ALUControl[0];
                     if (bus.ALUControl[2]) begin
                        lo   <= bus.SrcA;
                        opnd <= bus.SrcB;
                     end else begin
                        lo   <= bus.SrcB;
                        opnd <= bus.SrcA;
                     end
                  end else begin
                     state   <= DONE;
                     result  <= quick_res;
                     zero    <= (quick_res == '0);
                     illegal <= quick_ill;
                  end
               end
            end
            BUSY: begin
               hi  <= hi_next;
               lo  <= lo_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state   <= DONE;
                  result  <= fin;
                  zero    <= (fin == '0);
                  illegal <= 1'b0;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- scoreboard bench for seq_alu (WIDTH=32).
// The driver pushes the hand-computed expected response when it issues an
// operation; an independent monitor pops and compares each result as
// out_valid appears, and checks that held results stay stable.
module tb_seq_alu;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] res;
      logic         ill;
      int unsigned  lat;
      int unsigned  acc;
      string        name;
   } exp_t;

   logic clk;
   logic reset_n;
   int unsigned cyc;
   int unsigned checks;
   int unsigned passes;
   exp_t exp_q[$];

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv)
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
      else
         passes++;
   endtask

   // ---------------- monitor ----------------
   logic seen;
   exp_t cur;
   initial seen = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         seen = 1'b0;
      end else if (bus.out_valid) begin
         if (!seen) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", 64'd1, 64'd0);
            end else begin
               cur = exp_q.pop_front();
               check({cur.name, "_res"},  64'(bus.ALUResult), 64'(cur.res));
               check({cur.name, "_zero"}, 64'(bus.Zero), 64'(cur.res == '0));
               check({cur.name, "_ill"},  64'(bus.Illegal), 64'(cur.ill));
               check({cur.name, "_lat"},  64'(cyc - cur.acc + 1), 64'(cur.lat));
            end
            seen = 1'b1;
         end else begin
            check({cur.name, "_hold_res"},  64'(bus.ALUResult), 64'(cur.res));
            check({cur.name, "_hold_zero"}, 64'(bus.Zero), 64'(cur.res == '0));
            check({cur.name, "_hold_ill"},  64'(bus.Illegal), 64'(cur.ill));
         end
         if (bus.out_ready) seen = 1'b0;
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ei,
                        input int unsigned lat, input int unsigned noise);
      exp_t e;
      int unsigned guard;
      guard = 0;
      while (!bus.in_ready && guard < 200) begin
         step();
         guard++;
      end
      if (guard >= 200) begin
         check({name, "_ready_timeout"}, 64'd0, 64'd1);
      end else begin
         bus.SrcA       = a;
         bus.SrcB       = b;
         bus.ALUControl = op;
         bus.in_valid   = 1'b1;
         e.res  = er;
         e.ill  = ei;
         e.lat  = lat;
         e.acc  = cyc + 1;
         e.name = name;
         exp_q.push_back(e);
         step();
         bus.in_valid = 1'b0;
         bus.SrcA     = $urandom;
         bus.SrcB     = $urandom;
         // Garbage traffic while the operation is in flight (multi-cycle only).
         for (int i = 0; i < int'(noise); i++) begin
            bus.in_valid   = ~bus.in_valid;
            bus.SrcA       = $urandom;
            bus.SrcB       = $urandom;
            bus.ALUControl = 4'($urandom);
            step();
         end
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int unsigned guard;
      guard = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && guard < 200) begin
         step();
         guard++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int unsigned guard;
      bus.in_valid   = 1'b0;
      bus.SrcA       = '0;
      bus.SrcB       = '0;
      bus.ALUControl = '0;
      bus.out_ready  = 1'b1;
      checks = 0;
      passes = 0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_result",    64'(bus.ALUResult), 64'd0);
      check("rst_zero",      64'(bus.Zero), 64'd1);
      check("rst_illegal",   64'(bus.Illegal), 64'd0);
      reset_n = 1'b1;
      #1;
      check("rst_in_ready",  64'(bus.in_ready), 64'd1);
      step();

      // single-cycle ops
      issue("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0);
      issue("sub",      4'b0001, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1, 0);
      issue("and",      4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1, 0);
      issue("or",       4'b0011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1, 0);
      issue("xor",      4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1, 0);
      issue("slt",      4'b0101, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1, 0);
      issue("sltu",     4'b1001, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0);
      issue("srl",      4'b0110, 32'h8000_0000, 32'h21,        32'h4000_0000, 1'b0, 1, 0);
      issue("sll",      4'b0111, 32'h1,         32'h3F,        32'h8000_0000, 1'b0, 1, 0);
      issue("sra",      4'b1000, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1, 0);
      issue("ill_e",    4'b1110, 32'h1234,      32'h5678,      32'h0,         1'b1, 1, 0);
      issue("ill_f",    4'b1111, 32'hFFFF,      32'h1,         32'h0,         1'b1, 1, 0);

      // iterative ops
      issue("mul_lo",   4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b0, 33, 5);
      issue("mulhu",    4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h1,         1'b0, 33, 0);
      issue("mul_9",    4'b1010, 32'h1234_5678, 32'h9,         32'hA3D7_0A38, 1'b0, 33, 3);
      issue("mulhu_ff", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 0);
      issue("divu",     4'b1100, 32'd100,       32'd7,         32'd14,        1'b0, 33, 4);
      issue("remu",     4'b1101, 32'd100,       32'd7,         32'd2,         1'b0, 33, 0);
      issue("divu_0",   4'b1100, 32'h1234,      32'h0,         32'hFFFF_FFFF, 1'b0, 33, 0);
      issue("remu_0",   4'b1101, 32'd5,         32'h0,         32'd5,         1'b0, 33, 0);
      issue("divu_1",   4'b1100, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b0, 33, 0);
      issue("remu_sm",  4'b1101, 32'd7,         32'd100,       32'd7,         1'b0, 33, 0);
      drain();

      // hold result in DONE while the producer side misbehaves
      bus.out_ready = 1'b0;
      issue("hold_or", 4'b0011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1, 0);
      guard = 0;
      while (!bus.out_valid && guard < 50) begin
         step();
         guard++;
      end
      check("hold_reach_done", 64'(bus.out_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         bus.SrcA       = $urandom;
         bus.ALUControl = 4'b0000;
         bus.in_valid   = (i % 2 == 0);
         step();
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("hold_release_idle", 64'(bus.in_ready), 64'd1);
      check("hold_release_ov",   64'(bus.out_valid), 64'd0);

      // reset in the middle of a division
      issue("divu_rst", 4'b1100, 32'd1000, 32'd3, 32'd333, 1'b0, 33, 0);
      repeat (9) step();
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_result",    64'(bus.ALUResult), 64'd0);
      check("midrst_zero",      64'(bus.Zero), 64'd1);
      check("midrst_illegal",   64'(bus.Illegal), 64'd0);
      repeat (3) step();
      reset_n = 1'b1;
      repeat (40) step();
      issue("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);
      issue("ill_after_rst", 4'b1111, 32'd9, 32'd9, 32'd0, 1'b1, 1, 0);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
